agc_capture_sequencer: RTL and testbench

Sequences each measurement run around the auto-gain loop. On start it enables AGC and waits for the gain to report stable. It then requires a settle window with gain unchanged, and opens a fixed-length capture window for the downstream measurement buffer while asserting a gain-freeze request. A gain change or loss of stable during settle or capture invalidates the window and triggers a bounded retry; timeouts and exhausted retries report an error code.

---
 rtl/agc_pkg.sv | 28 ++
 rtl/agc_window_guard.sv | 35 +++
 rtl/agc_capture_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_agc_capture_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/agc_pkg.sv
// Shared types and default constants for the AGC capture sequencer.
package agc_pkg;

    // AGC gain code as reported by the gain loop.
    typedef logic [1:0] gain_t;

    // Sequencer states. The encoding is exported on the debug port.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_AGC_RUN  = 3'd1,
        S_SETTLE   = 3'd2,
        S_CAPTURE  = 3'd3,
        S_DONE     = 3'd4,
        S_ERROR    = 3'd5
    } seq_state_t;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE    = 2'b00;
    localparam err_code_t ERR_TIMEOUT = 2'b01;
    localparam err_code_t ERR_RETRY   = 2'b10;

    localparam int DEF_SETTLE_CYCLES  = 32;
    localparam int DEF_CAPTURE_LEN    = 1024;
    localparam int DEF_TIMEOUT_CYCLES = 65535;
    localparam int DEF_RETRY_MAX      = 3;

endpackage

// File: rtl/agc_window_guard.sv
// Window violation detector: holds the reference gain code and flags any
// cycle where the gain differs from it or the AGC drops its stable flag.
// The same reference serves both the settle and the capture window.
module agc_window_guard
    import agc_pkg::*;
(
    input  logic  adc_clk,
    input  logic  rst_n,
    input  logic  load_i,        // capture gain_ctrl_i as the new reference
    input  logic  check_i,       // window is open; report violations
    input  gain_t gain_ctrl_i,
    input  logic  agc_stable_i,
    output gain_t ref_o,
    output logic  viol_o
);

    gain_t ref_q;

    // Reference register, loaded when the sequencer leaves AGC_RUN for SETTLE.
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= '0;
        end else if (load_i) begin
            ref_q <= gain_ctrl_i;
        end
    end

    // Same-cycle violation so the sequencer reacts on the very next edge.
    always_comb begin
        viol_o = check_i && (!agc_stable_i || (gain_ctrl_i != ref_q));
    end

    assign ref_o = ref_q;

endmodule

// File: rtl/agc_capture_sequencer.sv
// Measurement-run sequencer around the auto-gain loop: enable AGC, wait for
// stable, require a clean settle window, then open a fixed capture window
// with gain frozen. Invalidated windows retry a bounded number of times.
// All outputs are registers loaded from the next-state decode, so they
// change on the same edge as the state register.
module agc_capture_sequencer
    import agc_pkg::*;
#(
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int CAPTURE_LEN    = DEF_CAPTURE_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int RETRY_MAX      = DEF_RETRY_MAX
) (
    input  logic       adc_clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] gain_ctrl,
    input  logic       agc_stable,
    output logic       agc_enable,
    output logic       agc_hold,
    output logic       cap_en,
    output logic       cap_start,
    output logic [1:0] gain_latched,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic [1:0] retry_cnt,
    output seq_state_t dbg_state_o
);

    localparam int SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int CW = $clog2(CAPTURE_LEN) + 1;

    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] SET_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CAP_LAST  = CW'(CAPTURE_LEN - 1);
    localparam logic [1:0] RETRY_LIMIT  = 2'(RETRY_MAX);

    seq_state_t      state_q, state_d;
    logic [15:0]     tmo_q, tmo_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [CW-1:0]   cap_q, cap_d;
    logic [1:0]      retry_q, retry_d;
    err_code_t       err_q, err_d;
    gain_t           glatch_q, glatch_d;

    logic agc_enable_q, agc_hold_q, cap_en_q, cap_start_q;
    logic busy_q, done_q, error_q;

    logic  ref_load;
    logic  win_check;
    logic  viol;
    gain_t ref_gain;

    assign win_check = (state_q == S_SETTLE) || (state_q == S_CAPTURE);

    agc_window_guard u_guard (
        .adc_clk      (adc_clk),
        .rst_n        (rst_n),
        .load_i       (ref_load),
        .check_i      (win_check),
        .gain_ctrl_i  (gain_ctrl),
        .agc_stable_i (agc_stable),
        .ref_o        (ref_gain),
        .viol_o       (viol)
    );

    // Next-state and counter decode; abort overrides every other event.
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        settle_d = settle_q;
        cap_d    = cap_q;
        retry_d  = retry_q;
        err_d    = err_q;
        glatch_d = glatch_q;
        ref_load = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        state_d = S_AGC_RUN;
                        retry_d = '0;
                        err_d   = ERR_NONE;
                        tmo_d   = '0;
                    end
                end
                S_AGC_RUN: begin
                    tmo_d = tmo_q + 16'd1;
                    // Stable wins over a timeout on the same cycle.
                    if (agc_stable) begin
                        state_d  = S_SETTLE;
                        ref_load = 1'b1;
                        settle_d = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = S_ERROR;
                        err_d   = ERR_TIMEOUT;
                    end
                end
                S_SETTLE: begin
                    // Settle violations are free: back to AGC_RUN, no retry.
                    if (viol) begin
                        state_d = S_AGC_RUN;
                        tmo_d   = '0;
                    end else if (settle_q == SET_LAST) begin
                        state_d  = S_CAPTURE;
                        glatch_d = ref_gain;
                        cap_d    = '0;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
                S_CAPTURE: begin
                    if (viol) begin
                        // retry_cnt saturates at the limit when the run errors out.
                        if (retry_q == RETRY_LIMIT) begin
                            state_d = S_ERROR;
                            err_d   = ERR_RETRY;
                        end else begin
                            retry_d = retry_q + 2'd1;
                            state_d = S_AGC_RUN;
                            tmo_d   = '0;
                        end
                    end else if (cap_q == CAP_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        cap_d = cap_q + CW'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counters and outputs registered together from the next-state decode.
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tmo_q        <= '0;
            settle_q     <= '0;
            cap_q        <= '0;
            retry_q      <= '0;
            err_q        <= ERR_NONE;
            glatch_q     <= '0;
            agc_enable_q <= 1'b0;
            agc_hold_q   <= 1'b0;
            cap_en_q     <= 1'b0;
            cap_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            settle_q     <= settle_d;
            cap_q        <= cap_d;
            retry_q      <= retry_d;
            err_q        <= err_d;
            glatch_q     <= glatch_d;
            agc_enable_q <= (state_d == S_AGC_RUN) || (state_d == S_SETTLE) ||
                            (state_d == S_CAPTURE) || (state_d == S_DONE);
            agc_hold_q   <= (state_d == S_CAPTURE);
            cap_en_q     <= (state_d == S_CAPTURE);
            cap_start_q  <= (state_d == S_CAPTURE) && (state_q != S_CAPTURE);
            busy_q       <= (state_d != S_IDLE) && (state_d != S_ERROR);
            done_q       <= (state_d == S_DONE);
            error_q      <= (state_d == S_ERROR);
        end
    end

    assign agc_enable   = agc_enable_q;
    assign agc_hold     = agc_hold_q;
    assign cap_en       = cap_en_q;
    assign cap_start    = cap_start_q;
    assign gain_latched = glatch_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_q;
    assign retry_cnt    = retry_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_agc_capture_sequencer.sv
// Bench for agc_capture_sequencer: directed runs, expected events queued by
// the stimulus, popped and compared by an independent monitor.
module tb_agc_capture_sequencer;
    import agc_pkg::*;

    localparam int CLK_HALF = 5;
    localparam int K_CAP_START = 1;
    localparam int K_CAP_END   = 2;
    localparam int K_DONE      = 3;
    localparam int K_ERROR     = 4;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] cyc;
        logic [1:0]  gain;
        logic [1:0]  retry;
        logic [1:0]  err;
        logic [15:0] len;
    } ev_t;
    localparam int EW = $bits(ev_t);

    logic [EW-1:0] exp_q[$];

    // clock / reset / DUT signals
    logic       adc_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] gain_ctrl = 2'b00;
    logic       agc_stable = 1'b0;
    logic       agc_enable, agc_hold, cap_en, cap_start, busy, done, error;
    logic [1:0] gain_latched, err_code, retry_cnt;
    logic [2:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic mon_en = 1'b0;

    always #CLK_HALF adc_clk = ~adc_clk;
    always @(posedge adc_clk) cyc <= cyc + 1;

    agc_capture_sequencer dut (
        .adc_clk      (adc_clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .gain_ctrl    (gain_ctrl),
        .agc_stable   (agc_stable),
        .agc_enable   (agc_enable),
        .agc_hold     (agc_hold),
        .cap_en       (cap_en),
        .cap_start    (cap_start),
        .gain_latched (gain_latched),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .retry_cnt    (retry_cnt),
        .dbg_state_o  (dbg_state)
    );

    // {agc_enable, agc_hold, cap_en, cap_start, busy, done, error, err_code, retry_cnt, gain_latched}
    function automatic logic [12:0] outs();
        return {agc_enable, agc_hold, cap_en, cap_start, busy, done, error,
                err_code, retry_cnt, gain_latched};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input logic [1:0] g,
                           input logic [1:0] r, input logic [1:0] e, input int len);
        ev_t ev;
        ev.kind  = 3'(kind);
        ev.cyc   = 32'(c);
        ev.gain  = g;
        ev.retry = r;
        ev.err   = e;
        ev.len   = 16'(len);
        exp_q.push_back(ev);
    endtask

    task automatic got_ev(input int kind, input int len);
        ev_t act;
        ev_t exp;
        act.kind  = 3'(kind);
        act.cyc   = 32'(cyc);
        act.gain  = gain_latched;
        act.retry = retry_cnt;
        act.err   = err_code;
        act.len   = 16'(len);
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event_unexpected: got kind=%0d cyc=%0d gain=%0d retry=%0d err=%0d len=%0d, required no event",
                     act.kind, act.cyc, act.gain, act.retry, act.err, act.len);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("FAIL event: got kind=%0d cyc=%0d gain=%0d retry=%0d err=%0d len=%0d, required kind=%0d cyc=%0d gain=%0d retry=%0d err=%0d len=%0d",
                         act.kind, act.cyc, act.gain, act.retry, act.err, act.len,
                         exp.kind, exp.cyc, exp.gain, exp.retry, exp.err, exp.len);
            end
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge adc_clk);
    endtask

    // monitor: watches for event edges on the falling clock and scores them
    initial begin
        logic prev_cap_en;
        logic prev_error;
        int   cap_len;
        prev_cap_en = 1'b0;
        prev_error  = 1'b0;
        cap_len     = 0;
        forever begin
            @(negedge adc_clk);
            if (mon_en) begin
                if (cap_start) cap_len = 0;
                if (cap_en) cap_len++;
                if (cap_start) got_ev(K_CAP_START, 0);
                if (prev_cap_en && !cap_en) got_ev(K_CAP_END, cap_len);
                if (done) got_ev(K_DONE, 0);
                if (error && !prev_error) got_ev(K_ERROR, 0);
                prev_cap_en = cap_en;
                prev_error  = error;
            end
        end
    end

    // watchdog
    initial begin
        #1500000;
        $display("FAIL watchdog: got time limit reached, required end of stimulus");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // driver / stimulus
    initial begin
        int c0;
        int s;
        int v;
        repeat (3) @(negedge adc_clk);
        check("reset_outputs", 32'(outs()), 32'h0);
        check("reset_state", 32'(dbg_state), 32'(S_IDLE));
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge adc_clk);

        // 1: clean run, stable from cycle 5, gain 01
        c0 = cyc;
        gain_ctrl = 2'b01; agc_stable = 1'b0; start = 1'b1;
        push_ev(K_CAP_START, c0 + 38,   2'b01, 2'd0, 2'd0, 0);
        push_ev(K_CAP_END,   c0 + 1062, 2'b01, 2'd0, 2'd0, 1024);
        push_ev(K_DONE,      c0 + 1062, 2'b01, 2'd0, 2'd0, 0);
        @(negedge adc_clk);
        start = 1'b0;
        check("t1_busy_enable", 32'({busy, agc_enable}), 32'b11);
        check("t1_state_run", 32'(dbg_state), 32'(S_AGC_RUN));
        wait_until(c0 + 5);
        agc_stable = 1'b1;
        wait_until(c0 + 6);
        check("t1_state_settle", 32'(dbg_state), 32'(S_SETTLE));
        wait_until(c0 + 100);
        start = 1'b1;            // ignored while busy
        wait_until(c0 + 101);
        start = 1'b0;
        wait_until(c0 + 1062);
        check("t1_done_busy", 32'({done, busy}), 32'b11);
        wait_until(c0 + 1063);
        check("t1_idle_outs", 32'(outs()), 32'({7'b0, 2'b00, 2'd0, 2'b01}));

        // 2: gain change at settle count 10 restarts settle, no retry
        wait_until(c0 + 1066);
        c0 = cyc;
        gain_ctrl = 2'b01; agc_stable = 1'b1; start = 1'b1;
        push_ev(K_CAP_START, c0 + 53,   2'b10, 2'd0, 2'd0, 0);
        push_ev(K_CAP_END,   c0 + 1077, 2'b10, 2'd0, 2'd0, 1024);
        push_ev(K_DONE,      c0 + 1077, 2'b10, 2'd0, 2'd0, 0);
        @(negedge adc_clk);
        start = 1'b0;
        wait_until(c0 + 12);
        gain_ctrl = 2'b10; agc_stable = 1'b0;
        wait_until(c0 + 13);
        check("t2_back_to_run", 32'({dbg_state, cap_en, retry_cnt}), 32'({S_AGC_RUN, 1'b0, 2'd0}));
        wait_until(c0 + 20);
        agc_stable = 1'b1;
        wait_until(c0 + 52);
        check("t2_full_settle", 32'({dbg_state, cap_en}), 32'({S_SETTLE, 1'b0}));
        wait_until(c0 + 1080);

        // 3: gain toggle at capture sample 500 on four consecutive windows
        c0 = cyc;
        gain_ctrl = 2'b01; agc_stable = 1'b1; start = 1'b1;
        s = c0 + 34;
        for (int k = 0; k < 4; k++) begin
            v = s + 500;
            push_ev(K_CAP_START, s, 2'b01, 2'(k), 2'd0, 0);
            push_ev(K_CAP_END, v + 1, 2'b01, (k < 3) ? 2'(k + 1) : 2'd3,
                    (k == 3) ? 2'b10 : 2'b00, 501);
            if (k == 3) push_ev(K_ERROR, v + 1, 2'b01, 2'd3, 2'b10, 0);
            s = v + 34;
        end
        @(negedge adc_clk);
        start = 1'b0;
        s = c0 + 34;
        for (int k = 0; k < 4; k++) begin
            v = s + 500;
            wait_until(v);
            gain_ctrl = 2'b10;
            wait_until(v + 1);
            gain_ctrl = 2'b01;
            if (k < 3) check("t3_retry_cnt", 32'({cap_en, retry_cnt}), 32'({1'b0, 2'(k + 1)}));
            s = v + 34;
        end
        check("t3_error_outs", 32'(outs()), 32'({7'b0000001, 2'b10, 2'd3, 2'b01}));
        check("t3_error_state", 32'(dbg_state), 32'(S_ERROR));

        // 4: stable never rises -> timeout error 65535 cycles after AGC_RUN entry
        repeat (3) @(negedge adc_clk);
        c0 = cyc;
        agc_stable = 1'b0; start = 1'b1;
        push_ev(K_ERROR, c0 + 65536, 2'b01, 2'd0, 2'b01, 0);
        @(negedge adc_clk);
        start = 1'b0;
        check("t4_start_clears", 32'({error, err_code, retry_cnt, agc_enable}), 32'({1'b0, 2'b00, 2'd0, 1'b1}));
        wait_until(c0 + 65535);
        check("t4_before_timeout", 32'({dbg_state, error}), 32'({S_AGC_RUN, 1'b0}));
        wait_until(c0 + 65536);
        check("t4_timeout_outs", 32'(outs()), 32'({7'b0000001, 2'b01, 2'd0, 2'b01}));

        // 5: abort together with start at capture sample 100
        repeat (2) @(negedge adc_clk);
        c0 = cyc;
        gain_ctrl = 2'b00; agc_stable = 1'b1; start = 1'b1;
        push_ev(K_CAP_START, c0 + 34,  2'b00, 2'd0, 2'd0, 0);
        push_ev(K_CAP_END,   c0 + 135, 2'b00, 2'd0, 2'd0, 101);
        @(negedge adc_clk);
        start = 1'b0;
        check("t5_start_clears", 32'({error, err_code}), 32'b0);
        wait_until(c0 + 134);
        abort = 1'b1; start = 1'b1;
        wait_until(c0 + 135);
        abort = 1'b0; start = 1'b0;
        check("t5_abort_outs", 32'(outs()), 32'h0);
        check("t5_abort_state", 32'(dbg_state), 32'(S_IDLE));
        wait_until(c0 + 140);
        check("t5_no_new_run", 32'({outs(), dbg_state}), 32'({13'h0, S_IDLE}));

        // 6: reset asserted at capture sample 300
        c0 = cyc;
        gain_ctrl = 2'b11; agc_stable = 1'b1; start = 1'b1;
        push_ev(K_CAP_START, c0 + 34,  2'b11, 2'd0, 2'd0, 0);
        push_ev(K_CAP_END,   c0 + 335, 2'b00, 2'd0, 2'd0, 301);
        @(negedge adc_clk);
        start = 1'b0;
        wait_until(c0 + 334);
        check("t6_pre_reset_gain", 32'({cap_en, gain_latched}), 32'({1'b1, 2'b11}));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_reset_outs", 32'(outs()), 32'h0);
        check("t6_reset_state", 32'(dbg_state), 32'(S_IDLE));
        repeat (3) @(negedge adc_clk);
        rst_n = 1'b1;
        repeat (5) @(negedge adc_clk);
        check("t6_idle_after_release", 32'({outs(), dbg_state}), 32'({13'h0, S_IDLE}));

        // drain: every queued event must have been seen
        repeat (4) @(negedge adc_clk);
        while (exp_q.size() != 0) begin
            ev_t ev;
            ev = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL event_missing: got nothing, required kind=%0d cyc=%0d gain=%0d retry=%0d err=%0d len=%0d",
                     ev.kind, ev.cyc, ev.gain, ev.retry, ev.err, ev.len);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
